// File: rtl/bot_video_pkg.sv
// Shared definitions for the RojoBot video controller: 640x480@60 Hz timing
// constants, the 2-bit world-map pixel codes and the 12-bit colour palette.
// Optional feature macro used by the importers: BOT_VIDEO_TEST_PATTERN_EN.
package bot_video_pkg;

  // Horizontal timing, in pixels
  localparam logic [9:0] H_VIS  = 10'd640;
  localparam logic [9:0] H_FP   = 10'd16;
  localparam logic [9:0] H_SYNC = 10'd96;
  localparam logic [9:0] H_BP   = 10'd48;
  localparam logic [9:0] HTOTAL = H_VIS + H_FP + H_SYNC + H_BP;    // 800
  localparam logic [9:0] H_LAST = HTOTAL - 10'd1;
  localparam logic [9:0] H_SYNC_FIRST = H_VIS + H_FP;              // 656
  localparam logic [9:0] H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 10'd1; // 751

  // Vertical timing, in lines
  localparam logic [9:0] V_VIS  = 10'd480;
  localparam logic [9:0] V_FP   = 10'd10;
  localparam logic [9:0] V_SYNC = 10'd2;
  localparam logic [9:0] V_BP   = 10'd33;
  localparam logic [9:0] VTOTAL = V_VIS + V_FP + V_SYNC + V_BP;    // 525
  localparam logic [9:0] V_LAST = VTOTAL - 10'd1;
  localparam logic [9:0] V_SYNC_FIRST = V_VIS + V_FP;              // 490
  localparam logic [9:0] V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 10'd1; // 491

  // The 128x120 map is scaled 4x, so it covers the left 512 columns
  localparam logic [9:0] MAP_H_PIX   = 10'd512;
  localparam logic [6:0] MAP_COL_MAX = 7'd127;

  // Map pixel codes returned by the bot
  typedef enum logic [1:0] {
    PIX_BG   = 2'b00,
    PIX_LINE = 2'b01,
    PIX_OBST = 2'b10,
    PIX_RSVD = 2'b11
  } map_pix_e;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb_t;

  localparam rgb_t COL_BG     = 12'hFFF;
  localparam rgb_t COL_LINE   = 12'h000;
  localparam rgb_t COL_OBST   = 12'hF00;
  localparam rgb_t COL_RSVD   = 12'h0F0;
  localparam rgb_t COL_BORDER = 12'h888;
  localparam rgb_t COL_OFF    = 12'h000;

  // Colour-bar generator: each bar bit drives one full colour channel
  function automatic rgb_t bar_color(input logic [2:0] bar);
    rgb_t c;
    c.red   = {4{bar[2]}};
    c.green = {4{bar[1]}};
    c.blue  = {4{bar[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_dtg.sv
// Display timing generator: pixel-rate prescaler plus horizontal and
// vertical position counters. Out-of-range counter values recover to 0
// on the next pixel tick.
module vga_dtg
  import bot_video_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       pix_tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;

  assign pix_tick = (presc == PRESC_MAX);

  // Prescaler: free-running 0..CLK_DIV-1, restarting from 0 after reset
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (presc >= PRESC_MAX) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Position counters: advance once per pixel, line wrap carries into vcnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_tick) begin
      if (hcnt >= H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt >= V_LAST) ? 10'd0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
        vcnt <= (vcnt > V_LAST) ? 10'd0 : vcnt;
      end
    end
  end

endmodule

// File: rtl/bot_video_ctl.sv
// RojoBot video controller: VGA timing, world-map addressing and the
// 2-bit map pixel to 12-bit RGB colorizer. All VGA outputs lag the
// position counters by one pixel period.
// Optional feature macro: BOT_VIDEO_TEST_PATTERN_EN adds test_sel, which
// replaces the map image with eight vertical colour bars.
module bot_video_ctl
  import bot_video_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int MAP_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
`ifdef BOT_VIDEO_TEST_PATTERN_EN
  input  logic       test_sel,
`endif
  input  logic [1:0] vid_pixel_in,
  output logic [6:0] vid_row,
  output logic [6:0] vid_col,
  output logic [3:0] vga_red,
  output logic [3:0] vga_green,
  output logic [3:0] vga_blue,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       frame_start
);

  // The map pixel is sampled on the tick clock, so it must settle first
  if (MAP_LATENCY >= CLK_DIV) begin : g_latency_check
    $error("bot_video_ctl: MAP_LATENCY must be smaller than CLK_DIV");
  end

  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       pix_tick;
  logic       visible;
  logic       in_map;
  rgb_t       rgb_next;
  rgb_t       rgb_q;

  vga_dtg #(
    .CLK_DIV (CLK_DIV)
  ) u_dtg (
    .clk      (clk),
    .rst_n    (reset),
    .hcnt     (hcnt),
    .vcnt     (vcnt),
    .pix_tick (pix_tick)
  );

  assign visible = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign in_map  = (hcnt < MAP_H_PIX) && (vcnt < V_VIS);

  // Address stage: map address tracks the counters, one clock behind
  // NOTE: reset is asynchronous and active-low; the sensitivity list names
  // negedge reset so outputs clear without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_row <= '0;
      vid_col <= '0;
    end else begin
      vid_col <= (hcnt < MAP_H_PIX) ? hcnt[8:2] : MAP_COL_MAX;
      vid_row <= vcnt[8:2];
    end
  end

  // Colorizer: choose the colour for the current counter position
  // NOTE: rgb_next gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rgb_next = COL_OFF;
    if (!visible) begin
      rgb_next = COL_OFF;
    end
`ifdef BOT_VIDEO_TEST_PATTERN_EN
    else if (test_sel) begin
      rgb_next = bar_color(hcnt[9:7]);
    end
`endif
    else if (!in_map) begin
      rgb_next = COL_BORDER;
    end else begin
      case (map_pix_e'(vid_pixel_in))
        PIX_BG:   rgb_next = COL_BG;
        PIX_LINE: rgb_next = COL_LINE;
        PIX_OBST: rgb_next = COL_OBST;
        PIX_RSVD: rgb_next = COL_RSVD;
      endcase
    end
  end

  // Output stage: register colour and syncs once per pixel tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q     <= COL_OFF;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else if (pix_tick) begin
      rgb_q     <= rgb_next;
      vga_hsync <= !((hcnt >= H_SYNC_FIRST) && (hcnt <= H_SYNC_LAST));
      vga_vsync <= !((vcnt >= V_SYNC_FIRST) && (vcnt <= V_SYNC_LAST));
    end
  end

  // Frame marker: one clock high when pixel (0,0) reaches the outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && (hcnt == 10'd0) && (vcnt == 10'd0);
    end
  end

  assign vga_red   = rgb_q.red;
  assign vga_green = rgb_q.green;
  assign vga_blue  = rgb_q.blue;

endmodule

// File: tb/tb_bot_video_ctl.sv
// Directed testbench for bot_video_ctl. A small bot map model answers
// address requests with one clock of latency. Far-away screen positions
// are reached by loading the position counters directly.
module tb_bot_video_ctl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] vid_pixel_in = 2'b00;
  logic [6:0] vid_row;
  logic [6:0] vid_col;
  logic [3:0] vga_red;
  logic [3:0] vga_green;
  logic [3:0] vga_blue;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       frame_start;
  logic [11:0] rgb;
`ifdef BOT_VIDEO_TEST_PATTERN_EN
  logic       test_sel = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;
  logic [9:0] f_h;
  logic [9:0] f_v;

  always #5 clk = ~clk;

  assign rgb = {vga_red, vga_green, vga_blue};

  bot_video_ctl #(
    .CLK_DIV     (4),
    .MAP_LATENCY (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef BOT_VIDEO_TEST_PATTERN_EN
    .test_sel     (test_sel),
`endif
    .vid_pixel_in (vid_pixel_in),
    .vid_row      (vid_row),
    .vid_col      (vid_col),
    .vga_red      (vga_red),
    .vga_green    (vga_green),
    .vga_blue     (vga_blue),
    .vga_hsync    (vga_hsync),
    .vga_vsync    (vga_vsync),
    .frame_start  (frame_start)
  );

  // Bot world map: obstruction at (10,20), line at (12,20), reserved at (12,21)
  function automatic logic [1:0] map_model(input logic [6:0] r, input logic [6:0] c);
    if (r == 7'd10 && c == 7'd20) return 2'b10;
    if (r == 7'd12 && c == 7'd20) return 2'b01;
    if (r == 7'd12 && c == 7'd21) return 2'b11;
    return 2'b00;
  endfunction

  always @(posedge clk) vid_pixel_in <= map_model(vid_row, vid_col);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle at the following falling edge
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      edge_cnt++;
    end
    @(negedge clk);
  endtask

  // Load (h,v) into the counters right after a tick; (h,v) is presented
  // on the outputs 4 clocks later, (h+k,v) after 4*(k+1) clocks.
  task automatic jump_run(input logic [9:0] h, input logic [9:0] v, input int ticks);
    f_h = h;
    f_v = v;
    force dut.u_dtg.hcnt = f_h;
    force dut.u_dtg.vcnt = f_v;
    #1;
    release dut.u_dtg.hcnt;
    release dut.u_dtg.vcnt;
    adv(4 * ticks);
  endtask

  initial begin
    int first_fall;
    int last_rise;
    int low_cnt;
    int fs_cnt;
    int vs_low;
    logic prev_hs;

    // Reset held for 10 clocks
    reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_hsync", vga_hsync, 1'b1);
    check("rst_vsync", vga_vsync, 1'b1);
    check("rst_rgb", rgb, 12'h000);
    check("rst_row", vid_row, 7'd0);
    check("rst_col", vid_col, 7'd0);
    check("rst_fs", frame_start, 1'b0);

    // Release: first tick on clock 4 presents pixel (0,0)
    reset = 1'b1;
    edge_cnt = 0;
    adv(3);
    check("pre_tick_rgb", rgb, 12'h000);
    check("pre_tick_fs", frame_start, 1'b0);
    adv(1);
    check("first_tick_fs", frame_start, 1'b1);
    check("first_tick_rgb", rgb, 12'hFFF);
    adv(1);
    check("fs_one_clk", frame_start, 1'b0);

    // First line, sampled every clock
    first_fall = -1;
    last_rise = -1;
    low_cnt = 0;
    fs_cnt = 0;
    vs_low = 0;
    prev_hs = vga_hsync;
    while (edge_cnt < 3204) begin
      adv(1);
      if (vga_hsync === 1'b0) low_cnt++;
      if (vga_vsync === 1'b0) vs_low++;
      if (frame_start === 1'b1) fs_cnt++;
      if (prev_hs === 1'b1 && vga_hsync === 1'b0 && first_fall < 0) first_fall = edge_cnt;
      if (prev_hs === 1'b0 && vga_hsync === 1'b1) last_rise = edge_cnt;
      prev_hs = vga_hsync;
      if (edge_cnt == 404) begin
        check("h100_col", vid_col, 7'd25);
        check("h100_rgb", rgb, 12'hFFF);
      end
      if (edge_cnt == 2048) check("h511_rgb", rgb, 12'hFFF);
      if (edge_cnt == 2052) begin
        check("h512_rgb", rgb, 12'h888);
        check("h512_col", vid_col, 7'd127);
      end
      if (edge_cnt == 2560) check("h639_rgb", rgb, 12'h888);
      if (edge_cnt == 2564) check("h640_rgb", rgb, 12'h000);
    end
    check("hsync_first_fall", first_fall, 32'd2628);
    check("hsync_rise", last_rise, 32'd3012);
    check("hsync_low_clks", low_cnt, 32'd384);
    check("line0_fs_cnt", fs_cnt, 32'd0);
    check("line0_vsync_low", vs_low, 32'd0);

    // Obstruction pixel (10,20) covers hcnt 80..83, vcnt 40..43
    jump_run(10'd76, 10'd40, 4);
    check("obst_h79", rgb, 12'hFFF);
    adv(4);
    check("obst_h80", rgb, 12'hF00);
    adv(12);
    check("obst_h83", rgb, 12'hF00);
    adv(4);
    check("obst_h84", rgb, 12'hFFF);
    jump_run(10'd76, 10'd43, 5);
    check("obst_v43", rgb, 12'hF00);
    jump_run(10'd76, 10'd44, 5);
    check("obst_v44", rgb, 12'hFFF);
    jump_run(10'd76, 10'd48, 5);
    check("line_pix", rgb, 12'h000);
    adv(16);
    check("rsvd_pix", rgb, 12'h0F0);

    // Vertical boundaries and vsync
    jump_run(10'd100, 10'd479, 1);
    check("v479_rgb", rgb, 12'hFFF);
    jump_run(10'd100, 10'd480, 1);
    check("v480_rgb", rgb, 12'h000);
    jump_run(10'd795, 10'd489, 5);
    check("vs_v489", vga_vsync, 1'b1);
    adv(4);
    check("vs_v490", vga_vsync, 1'b0);
    check("v490_rgb", rgb, 12'h000);
    jump_run(10'd795, 10'd491, 5);
    check("vs_v491", vga_vsync, 1'b0);
    adv(4);
    check("vs_v492", vga_vsync, 1'b1);

    // Frame wrap 524 -> 0
    jump_run(10'd798, 10'd524, 2);
    check("wrap_fs_h799", frame_start, 1'b0);
    adv(4);
    check("wrap_fs_00", frame_start, 1'b1);
    check("wrap_row", vid_row, 7'd0);
    adv(1);
    check("wrap_fs_off", frame_start, 1'b0);
    adv(3);

    // Out-of-range vcnt recovers to 0 on the next tick
    jump_run(10'd100, 10'd600, 0);
    adv(1);
    check("illegal_row", vid_row, 7'd22);
    adv(3);
    check("illegal_rgb", rgb, 12'h000);
    adv(1);
    check("recover_row", vid_row, 7'd0);
    adv(3);

    // Reset mid-line at (300,200)
    jump_run(10'd300, 10'd200, 1);
    check("mid_rgb", rgb, 12'hFFF);
    check("mid_row", vid_row, 7'd50);
    reset = 1'b0;
    #1;
    check("async_rgb", rgb, 12'h000);
    check("async_row", vid_row, 7'd0);
    check("async_col", vid_col, 7'd0);
    check("async_hsync", vga_hsync, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    edge_cnt = 0;
    adv(3);
    check("restart_pre_fs", frame_start, 1'b0);
    adv(1);
    check("restart_fs", frame_start, 1'b1);
    check("restart_rgb", rgb, 12'hFFF);

`ifdef BOT_VIDEO_TEST_PATTERN_EN
    // Colour bars replace the map; timing is unchanged
    test_sel = 1'b1;
    jump_run(10'd0, 10'd0, 1);
    check("bar_h0", rgb, 12'h000);
    jump_run(10'd128, 10'd0, 1);
    check("bar_h128", rgb, 12'h00F);
    jump_run(10'd384, 10'd0, 1);
    check("bar_h384", rgb, 12'h0FF);
    jump_run(10'd80, 10'd40, 1);
    check("bar_ignore_map", rgb, 12'h000);
    jump_run(10'd640, 10'd0, 1);
    check("bar_h640", rgb, 12'h000);
    jump_run(10'd655, 10'd0, 1);
    check("bar_hs_h655", vga_hsync, 1'b1);
    adv(4);
    check("bar_hs_h656", vga_hsync, 1'b0);
    jump_run(10'd795, 10'd489, 6);
    check("bar_vs_v490", vga_vsync, 1'b0);
    test_sel = 1'b0;
    jump_run(10'd80, 10'd40, 1);
    check("bar_off_map", rgb, 12'hF00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
